// File: rtl/biquad_mac_seq_if.sv
// biquad_mac_seq_if: sample-in / sample-out stream between a producer and the biquad section.
interface biquad_mac_seq_if #(
    parameter int DATAWIDTH = 16
);
    logic signed [DATAWIDTH-1:0] x_in;
    logic                        x_valid;
    logic                        ready;
    logic signed [DATAWIDTH-1:0] y_out;
    logic                        y_valid;

    modport master (output x_in, x_valid, input ready, y_out, y_valid);
    modport slave  (input x_in, x_valid, output ready, y_out, y_valid);
endinterface

// File: rtl/biquad_mac_seq.sv
// biquad_mac_seq: time-shared direct-form-I biquad, one sign-magnitude tap per cycle through an external multiplier.
module biquad_mac_seq #(
    parameter int DATAWIDTH = 16,
    parameter int COEFWIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    biquad_mac_seq_if.slave                      s,
    input  logic signed [COEFWIDTH-1:0]          b0,
    input  logic signed [COEFWIDTH-1:0]          b1,
    input  logic signed [COEFWIDTH-1:0]          b2,
    input  logic signed [COEFWIDTH-1:0]          a1,
    input  logic signed [COEFWIDTH-1:0]          a2,
    output logic [COEFWIDTH-2:0]                 mult_a,
    output logic [DATAWIDTH+2:0]                 mult_b,
    input  logic [DATAWIDTH+COEFWIDTH+1:0]       mult_p,
    output logic                                 overflow
);
    localparam int DW = DATAWIDTH;
    localparam int CW = COEFWIDTH;
    localparam int AW = DATAWIDTH + COEFWIDTH + 2;
    localparam logic signed [AW-1:0] RND  = AW'(2 ** (CW - 3));
    localparam logic signed [AW-1:0] MAXV = AW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;
    localparam logic signed [DW-1:0] YMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] YMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [CW-1:0] CMIN = {1'b1, {(CW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                 state;
    logic [2:0]             tap;
    logic signed [DW-1:0]   xr, x1, x2, y1, y2, y_q;
    logic signed [CW-1:0]   cb0, cb1, cb2, ca1, ca2;
    logic signed [AW-1:0]   acc;
    logic                   y_v;

    logic signed [CW-1:0]   coef;
    logic signed [DW-1:0]   data;
    logic [CW-1:0]          c_neg;
    logic [DW:0]            d_ext, d_neg;
    logic                   p_neg;
    logic signed [AW-1:0]   prod, rnd;
    logic signed [DW-1:0]   y_new;
    logic                   sat;

    always_comb begin
        coef  = tap == 3'd0 ? cb0 : tap == 3'd1 ? cb1 : tap == 3'd2 ? cb2 : tap == 3'd3 ? ca1 : ca2;
        data  = tap == 3'd0 ? xr  : tap == 3'd1 ? x1  : tap == 3'd2 ? x2  : tap == 3'd3 ? y1  : y2;
        c_neg = -coef;
        d_ext = {data[DW-1], data};
        d_neg = -d_ext;
        // The most negative coefficient has no positive twin in CW-1 bits, so it is clamped.
        mult_a = state != MAC ? '0 : coef == CMIN ? '1 : coef[CW-1] ? c_neg[CW-2:0] : coef[CW-2:0];
        mult_b = state != MAC ? '0 : {2'b00, data[DW-1] ? d_neg : d_ext};
        // Feedback taps are subtracted, folded into the product sign.
        p_neg = coef[CW-1] ^ data[DW-1] ^ (tap >= 3'd3);
        prod  = p_neg ? -$signed(mult_p) : $signed(mult_p);
        rnd   = (acc + RND) >>> (CW - 2);
        sat   = rnd > MAXV || rnd < MINV;
        y_new = rnd > MAXV ? YMAX : rnd < MINV ? YMIN : rnd[DW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tap      <= '0;
            xr       <= '0;
            x1       <= '0;
            x2       <= '0;
            y1       <= '0;
            y2       <= '0;
            y_q      <= '0;
            cb0      <= '0;
            cb1      <= '0;
            cb2      <= '0;
            ca1      <= '0;
            ca2      <= '0;
            acc      <= '0;
            y_v      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            y_v <= 1'b0;
            case (state)
                IDLE: if (s.x_valid) begin
                    xr    <= s.x_in;
                    cb0   <= b0;
                    cb1   <= b1;
                    cb2   <= b2;
                    ca1   <= a1;
                    ca2   <= a2;
                    acc   <= '0;
                    tap   <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc   <= acc + prod;
                    tap   <= tap + 3'd1;
                    state <= tap == 3'd4 ? OUT : MAC;
                end
                OUT: begin
                    y_q      <= y_new;
                    y_v      <= 1'b1;
                    overflow <= overflow | sat;
                    x2       <= x1;
                    x1       <= xr;
                    y2       <= y1;
                    y1       <= y_new;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s.ready   = state == IDLE;
    assign s.y_out   = y_q;
    assign s.y_valid = y_v;
endmodule

// File: tb/tb_biquad_mac_seq.sv
// tb_biquad_mac_seq: directed and randomized checks of the biquad section against an arithmetic reference.
module tb_biquad_mac_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [15:0] b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;
    logic [14:0] mult_a;
    logic [18:0] mult_b;
    logic [33:0] mult_p;
    logic overflow;
    int total = 0, passed = 0;
    longint mx1, mx2, my1, my2;
    bit movf;
    int yq[$];

    biquad_mac_seq_if #(.DATAWIDTH(16)) bus();

    biquad_mac_seq dut (
        .clk(clk), .reset(reset), .s(bus),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p), .overflow(overflow)
    );

    // Stand-in for the multa block: plain unsigned product.
    assign mult_p = {19'd0, mult_a} * {15'd0, mult_b};

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic longint cl(input logic signed [15:0] c);
        return c == 16'sh8000 ? -64'sd32767 : longint'(c);
    endfunction

    function automatic longint mag(input longint v);
        return v < 0 ? -v : v;
    endfunction

    task automatic model_clear();
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0; movf = 0;
    endtask

    task automatic predict(input int x, output int y);
        longint acc, r;
        acc = cl(b0) * x + cl(b1) * mx1 + cl(b2) * mx2 - cl(a1) * my1 - cl(a2) * my2;
        r = (acc + 8192) >>> 14;
        if (r > 32767) begin r = 32767; movf = 1; end
        else if (r < -32768) begin r = -32768; movf = 1; end
        y = int'(r);
        mx2 = mx1; mx1 = x; my2 = my1; my1 = r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.x_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        check("rst_ready", bus.ready, 1);
        check("rst_y_out", bus.y_out, 0);
        check("rst_y_valid", bus.y_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_mult_a", mult_a, 0);
        check("rst_mult_b", mult_b, 0);
    endtask

    task automatic run(input int x, input bit scramble, output int yo);
        int n, ey;
        longint ea, eb;
        @(negedge clk);
        check("ready_idle", bus.ready, 1);
        ea = mag(cl(b0));
        eb = mag(x);
        predict(x, ey);
        bus.x_in = 16'(x);
        bus.x_valid = 1'b1;
        @(negedge clk);
        bus.x_valid = 1'b0;
        if (scramble) begin
            b0 = 16'($urandom); b1 = 16'($urandom); b2 = 16'($urandom);
            a1 = 16'($urandom); a2 = 16'($urandom);
        end
        check("tap0_mult_a", mult_a, ea);
        check("tap0_mult_b", mult_b, eb);
        n = 0;
        while (!bus.y_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("latency", n, 6);
        check("y_out", bus.y_out, ey);
        check("ready_with_valid", bus.ready, 1);
        check("overflow", overflow, movf);
        yo = bus.y_out;
        @(negedge clk);
        check("y_valid_pulse", bus.y_valid, 0);
    endtask

    initial begin
        int y, ey, pulses;
        int imp[6];
        int xs[28];
        bus.x_in = '0;
        bus.x_valid = 1'b0;

        // Passthrough
        do_reset();
        b0 = 16384;
        run(1000, 0, y);
        check("pass_const", y, 1000);

        // Delay line
        do_reset();
        b0 = 0; b2 = 16384;
        run(100, 0, y); check("delay0", y, 0);
        run(200, 0, y); check("delay1", y, 0);
        run(300, 0, y); check("delay2", y, 100);

        // Feedback with round-half-up
        do_reset();
        b0 = 16384; b2 = 0; a1 = -8192;
        imp = '{1000, 500, 250, 125, 63, 32};
        for (int i = 0; i < 6; i++) begin
            run(i == 0 ? 1000 : 0, 0, y);
            check("feedback", y, imp[i]);
        end

        // Saturation, sticky overflow, coefficient clamp
        do_reset();
        b0 = 32767; a1 = 0;
        run(32767, 0, y);
        check("sat_pos", y, 32767);
        check("ovf_set", overflow, 1);
        run(-32768, 0, y);
        check("sat_neg", y, -32768);
        check("ovf_sticky", overflow, 1);
        do_reset();
        b0 = -32768;
        run(16384, 0, y);
        check("clamp_coef", y, -32767);

        // Busy handshake: x_valid held high, only every 7th cycle is accepted
        do_reset();
        b0 = 16384; b1 = 8192;
        for (int k = 0; k < 28; k++) xs[k] = int'($urandom_range(20000)) - 10000;
        @(negedge clk);
        for (int k = 0; k <= 28; k++) begin
            if (k > 0) begin
                check("busy_valid", bus.y_valid, (k % 7) == 0);
                if (k % 7 == 0 && yq.size() > 0) check("busy_y", bus.y_out, yq.pop_front());
            end
            if (k < 28) begin
                bus.x_valid = 1'b1;
                bus.x_in = 16'(xs[k]);
                if (k % 7 == 0) begin
                    predict(xs[k], ey);
                    yq.push_back(ey);
                end
                @(negedge clk);
            end else bus.x_valid = 1'b0;
        end
        check("busy_drained", yq.size(), 0);

        // Reset during tap 3
        do_reset();
        b0 = 16384; b1 = 0;
        @(negedge clk);
        bus.x_in = 500;
        bus.x_valid = 1'b1;
        @(negedge clk);
        bus.x_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_y_out", bus.y_out, 0);
        check("midrst_ready", bus.ready, 1);
        check("midrst_y_valid", bus.y_valid, 0);
        check("midrst_mult_a", mult_a, 0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.y_valid) pulses++;
        end
        check("midrst_no_valid", pulses, 0);
        run(500, 0, y);
        check("midrst_after", y, 500);

        // Randomized coefficients and samples, coefficients disturbed while in flight
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7) == 0) begin
                b0 = 16'($urandom); b1 = 16'($urandom); b2 = 16'($urandom);
                a1 = 16'($urandom); a2 = 16'($urandom);
            end else begin
                b0 = 16'(int'($urandom_range(32767)) - 16384);
                b1 = 16'(int'($urandom_range(16383)) - 8192);
                b2 = 16'(int'($urandom_range(16383)) - 8192);
                a1 = 16'(int'($urandom_range(16383)) - 8192);
                a2 = 16'(int'($urandom_range(8191)) - 4096);
            end
            run(int'($urandom_range(65535)) - 32768, 1, y);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
